// File: rtl/nn_pkg.sv
// Shared types and constants for the layer sequencer slice.
// States, descriptor word indices and table geometry.
package nn_pkg;

    localparam int MAX_LAYERS    = 8;
    localparam int LAYER_W       = 3;
    localparam int PE_SIZE       = 16;
    localparam int NUM_CFG_WORDS = 5;

    localparam logic [2:0] W_INADDR = 3'd0;
    localparam logic [2:0] W_WADDR  = 3'd1;
    localparam logic [2:0] W_OUTADR = 3'd2;
    localparam logic [2:0] W_NIN    = 3'd3;
    localparam logic [2:0] W_NOUT   = 3'd4;

    typedef logic [2:0] state_t;

    localparam state_t S_IDLE   = 3'd0;
    localparam state_t S_CHECK  = 3'd1;
    localparam state_t S_ENABLE = 3'd2;
    localparam state_t S_SEND   = 3'd3;
    localparam state_t S_RUN    = 3'd4;
    localparam state_t S_NEXT   = 3'd5;
    localparam state_t S_DONE   = 3'd6;

endpackage

// File: rtl/nn_layer_sequencer_if.sv
// Host and accelerator side signals of the layer sequencer.
// master = host/accelerator environment, slave = sequencer.
interface nn_layer_sequencer_if;
    import nn_pkg::*;

    logic                 host_wr;
    logic [LAYER_W+2:0]   host_addr;
    logic [15:0]          host_wdata;
    logic                 host_start;
    logic [LAYER_W:0]     num_layers;
    logic                 accel_enable;
    logic                 accel_busrdwr;
    logic [15:0]          accel_databus;
    logic                 accel_neuron_done;
    logic                 busy;
    logic                 done;
    logic                 error;
    logic [LAYER_W-1:0]   cur_layer;

    modport master (
        output host_wr, host_addr, host_wdata, host_start,
        output num_layers, accel_neuron_done,
        input  accel_enable, accel_busrdwr, accel_databus,
        input  busy, done, error, cur_layer
    );

    modport slave (
        input  host_wr, host_addr, host_wdata, host_start,
        input  num_layers, accel_neuron_done,
        output accel_enable, accel_busrdwr, accel_databus,
        output busy, done, error, cur_layer
    );

endinterface

// File: rtl/nn_desc_table.sv
// Descriptor table: MAX_LAYERS entries of five 16-bit words.
// One write port, two combinational read ports on the same layer.
module nn_desc_table
    import nn_pkg::*;
(
    input  logic               clk,
    input  logic               we_i,
    input  logic [LAYER_W-1:0] wlayer_i,
    input  logic [2:0]         wword_i,
    input  logic [15:0]        wdata_i,
    input  logic [LAYER_W-1:0] rlayer_i,
    input  logic [2:0]         raword_i,
    output logic [15:0]        radata_o,
    input  logic [2:0]         rbword_i,
    output logic [15:0]        rbdata_o
);

    logic [15:0] mem_q [MAX_LAYERS][NUM_CFG_WORDS];

    // Table contents are not reset so they survive rst.
    always_ff @(posedge clk) begin
        if (we_i && (wword_i < 3'(NUM_CFG_WORDS))) begin
            mem_q[wlayer_i][wword_i] <= wdata_i;
        end
    end

    // Out-of-range word indices read as zero.
    always_comb begin
        radata_o = '0;
        rbdata_o = '0;
        if (raword_i < 3'(NUM_CFG_WORDS)) begin
            radata_o = mem_q[rlayer_i][raword_i];
        end
        if (rbword_i < 3'(NUM_CFG_WORDS)) begin
            rbdata_o = mem_q[rlayer_i][rbword_i];
        end
    end

endmodule

// File: rtl/nn_layer_sequencer.sv
// Multi-layer scheduler driving the accelerator config bus.
// Optional RUN watchdog enabled by defining SEQ_TIMEOUT_EN.
module nn_layer_sequencer
    import nn_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                  clk,
    input  logic                  rst,
    nn_layer_sequencer_if.slave   bus
);

    state_t             state_q, state_d;
    logic [LAYER_W-1:0] cur_q, cur_d;
    logic [LAYER_W:0]   nl_q, nl_d;
    logic [2:0]         wcnt_q, wcnt_d;
    logic [15:0]        cnt_q, cnt_d;
    logic               err_q, err_d;

    logic [15:0]        ra_data;
    logic [15:0]        rb_data;
    logic [2:0]         ra_word;
    logic [15:0]        cnt_inc;
    logic [LAYER_W:0]   cur_ext;
    logic               tbl_we;
    logic               bad_desc;

`ifdef SEQ_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WD_W-1:0]    wd_q, wd_d;
`else
    logic               unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

    assign tbl_we  = bus.host_wr && (state_q == S_IDLE);
    assign ra_word = (state_q == S_SEND) ? wcnt_q : W_NIN;

    nn_desc_table u_table (
        .clk      (clk),
        .we_i     (tbl_we),
        .wlayer_i (bus.host_addr[LAYER_W+2:3]),
        .wword_i  (bus.host_addr[2:0]),
        .wdata_i  (bus.host_wdata),
        .rlayer_i (cur_q),
        .raword_i (ra_word),
        .radata_o (ra_data),
        .rbword_i (W_NOUT),
        .rbdata_o (rb_data)
    );

    assign cnt_inc  = cnt_q + 16'(bus.accel_neuron_done);
    assign cur_ext  = {1'b0, cur_q} + {{LAYER_W{1'b0}}, 1'b1};
    assign bad_desc = (ra_data == '0)
                   || ((ra_data % 16'(PE_SIZE)) != '0)
                   || (rb_data == '0);

    // Next-state logic for the layer scheduling FSM.
    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        nl_d    = nl_q;
        wcnt_d  = wcnt_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
`ifdef SEQ_TIMEOUT_EN
        wd_d    = '0;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (bus.host_start) begin
                    nl_d    = bus.num_layers;
                    err_d   = 1'b0;
                    cur_d   = '0;
                    cnt_d   = '0;
                    state_d = (bus.num_layers == '0) ? S_DONE : S_CHECK;
                end
            end
            S_CHECK: begin
                if (bad_desc) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    state_d = S_ENABLE;
                end
            end
            S_ENABLE: begin
                wcnt_d  = '0;
                state_d = S_SEND;
            end
            S_SEND: begin
                if (wcnt_q == 3'(NUM_CFG_WORDS - 1)) begin
                    cnt_d   = '0;
                    state_d = S_RUN;
                end else begin
                    wcnt_d = wcnt_q + 3'd1;
                end
            end
            S_RUN: begin
                cnt_d = cnt_inc;
                if (cnt_inc == rb_data) begin
                    state_d = S_NEXT;
                end
`ifdef SEQ_TIMEOUT_EN
                else begin
                    wd_d = bus.accel_neuron_done ? '0 : wd_q + 1'b1;
                    if (wd_d == WD_W'(TIMEOUT_CYCLES)) begin
                        err_d   = 1'b1;
                        state_d = S_IDLE;
                    end
                end
`endif
            end
            S_NEXT: begin
                cnt_d = '0;
                if (cur_ext == nl_q) begin
                    state_d = S_DONE;
                end else begin
                    cur_d   = cur_q + 1'b1;
                    state_d = S_CHECK;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and counter registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cur_q   <= '0;
            nl_q    <= '0;
            wcnt_q  <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
`ifdef SEQ_TIMEOUT_EN
            wd_q    <= '0;
`endif
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            nl_q    <= nl_d;
            wcnt_q  <= wcnt_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
`ifdef SEQ_TIMEOUT_EN
            wd_q    <= wd_d;
`endif
        end
    end

    // Outputs decode directly from the current state.
    always_comb begin
        bus.busy          = (state_q == S_CHECK) || (state_q == S_ENABLE)
                         || (state_q == S_SEND) || (state_q == S_RUN)
                         || (state_q == S_NEXT);
        bus.done          = (state_q == S_DONE);
        bus.accel_enable  = (state_q == S_ENABLE);
        bus.accel_busrdwr = (state_q == S_SEND);
        bus.accel_databus = (state_q == S_SEND) ? ra_data : '0;
        bus.error         = err_q;
        bus.cur_layer     = cur_q;
    end

endmodule

// File: tb/tb_nn_layer_sequencer.sv
// Self-checking bench for nn_layer_sequencer.
// Reference: descriptor table mirror plus per-layer event model.
module tb_nn_layer_sequencer;
    import nn_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    nn_layer_sequencer_if bus();

    nn_layer_sequencer #(.TIMEOUT_CYCLES(64)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int failures = 0;
    logic [15:0] tbl [MAX_LAYERS][NUM_CFG_WORDS];
    int en_cnt = 0;
    int done_cnt = 0;

    always @(negedge clk) begin
        if (bus.accel_enable === 1'b1) en_cnt++;
        if (bus.done === 1'b1) done_cnt++;
    end

    task automatic idle_inputs();
        bus.host_wr = 1'b0;
        bus.host_addr = '0;
        bus.host_wdata = '0;
        bus.host_start = 1'b0;
        bus.num_layers = '0;
        bus.accel_neuron_done = 1'b0;
    endtask

    task automatic wr(input int l, input int w, input logic [15:0] d);
        bus.host_wr = 1'b1;
        bus.host_addr = {3'(l), 3'(w)};
        bus.host_wdata = d;
        @(negedge clk);
        bus.host_wr = 1'b0;
        if (w < NUM_CFG_WORDS) tbl[l][w] = d;
    endtask

    task automatic wr_layer(input int l, input logic [15:0] a,
                            input logic [15:0] b, input logic [15:0] c,
                            input logic [15:0] nin, input logic [15:0] nout);
        wr(l, 0, a);
        wr(l, 1, b);
        wr(l, 2, c);
        wr(l, 3, nin);
        wr(l, 4, nout);
    endtask

    function automatic logic outs_zero();
        return bus.busy === 1'b0 && bus.done === 1'b0
            && bus.accel_enable === 1'b0 && bus.accel_busrdwr === 1'b0
            && bus.accel_databus === 16'h0 && bus.error === 1'b0
            && bus.cur_layer === 3'd0;
    endfunction

    // Runs n layers from the model table; stray puts a pulse in SEND.
    task automatic run_layers(input int n, input bit stray);
        int e0;
        int d0;
        int nin;
        int nout;
        e0 = en_cnt;
        d0 = done_cnt;
        bus.host_start = 1'b1;
        bus.num_layers = 4'(n);
        @(negedge clk);
        bus.host_start = 1'b0;
        checks++;
        if (bus.error !== 1'b0 || bus.busy !== (n != 0)) begin
            failures++;
            $display("FAIL start_state: err=%b busy=%b exp err=0 busy=%b",
                     bus.error, bus.busy, n != 0);
        end
        if (n == 0) begin
            checks++;
            if (bus.done !== 1'b1) begin
                failures++;
                $display("FAIL zero_done: done=%b exp 1", bus.done);
            end
            @(negedge clk);
            checks++;
            if (bus.done !== 1'b0 || bus.busy !== 1'b0 || en_cnt != e0) begin
                failures++;
                $display("FAIL zero_after: done=%b busy=%b en=%0d exp 0 0 0",
                         bus.done, bus.busy, en_cnt - e0);
            end
            return;
        end
        for (int l = 0; l < n; l++) begin
            nin = int'(tbl[l][3]);
            nout = int'(tbl[l][4]);
            checks++;
            if (bus.cur_layer !== 3'(l)) begin
                failures++;
                $display("FAIL cur_layer: got %0d exp %0d", bus.cur_layer, l);
            end
            if (nin == 0 || nin % PE_SIZE != 0 || nout == 0) begin
                @(negedge clk);
                checks++;
                if (bus.error !== 1'b1 || bus.busy !== 1'b0) begin
                    failures++;
                    $display("FAIL bad_desc: err=%b busy=%b exp 1 0",
                             bus.error, bus.busy);
                end
                @(negedge clk);
                checks++;
                if (done_cnt != d0 || en_cnt != e0 + l) begin
                    failures++;
                    $display("FAIL bad_counts: done=%0d en=%0d exp 0 %0d",
                             done_cnt - d0, en_cnt - e0, l);
                end
                return;
            end
            @(negedge clk);
            checks++;
            if (bus.accel_enable !== 1'b1 || bus.accel_busrdwr !== 1'b0) begin
                failures++;
                $display("FAIL enable: en=%b rdwr=%b exp 1 0",
                         bus.accel_enable, bus.accel_busrdwr);
            end
            for (int k = 0; k < NUM_CFG_WORDS; k++) begin
                @(negedge clk);
                bus.accel_neuron_done = stray && (k == 2);
                checks++;
                if (bus.accel_busrdwr !== 1'b1
                    || bus.accel_databus !== tbl[l][k]) begin
                    failures++;
                    $display("FAIL word%0d: rdwr=%b data=%h exp 1 %h",
                             k, bus.accel_busrdwr, bus.accel_databus, tbl[l][k]);
                end
            end
            bus.accel_neuron_done = 1'b0;
            @(negedge clk);
            checks++;
            if (bus.accel_busrdwr !== 1'b0 || bus.accel_databus !== 16'h0
                || bus.busy !== 1'b1) begin
                failures++;
                $display("FAIL run_entry: rdwr=%b data=%h busy=%b exp 0 0 1",
                         bus.accel_busrdwr, bus.accel_databus, bus.busy);
            end
            for (int p = 0; p < nout; p++) begin
                repeat ($urandom_range(0, 3)) @(negedge clk);
                bus.accel_neuron_done = 1'b1;
                @(negedge clk);
                bus.accel_neuron_done = 1'b0;
            end
            @(negedge clk);
        end
        checks++;
        if (bus.done !== 1'b1 || bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL done_pulse: done=%b busy=%b exp 1 0",
                     bus.done, bus.busy);
        end
        @(negedge clk);
        checks++;
        if (bus.done !== 1'b0 || done_cnt != d0 + 1 || en_cnt != e0 + n
            || bus.error !== 1'b0) begin
            failures++;
            $display("FAIL done_after: done=%b dones=%0d ens=%0d exp 0 1 %0d",
                     bus.done, done_cnt - d0, en_cnt - e0, n);
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (!outs_zero()) begin
            failures++;
            $display("FAIL reset: busy=%b done=%b en=%b err=%b exp all 0",
                     bus.busy, bus.done, bus.accel_enable, bus.error);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single();
        wr_layer(0, 16'h0100, 16'h2000, 16'h0400, 16'd32, 16'd3);
        wr(0, 5, 16'hdead);
        wr(0, 6, 16'hbeef);
        wr(0, 7, 16'hcafe);
        run_layers(1, 1'b0);
        run_layers(1, 1'b1);
    endtask

    task automatic test_multi();
        wr_layer(0, 16'h0011, 16'h0022, 16'h0033, 16'd16, 16'd2);
        wr_layer(1, 16'h0111, 16'h0122, 16'h0133, 16'd48, 16'd4);
        wr_layer(2, 16'h0211, 16'h0222, 16'h0233, 16'd64, 16'd1);
        run_layers(3, 1'b0);
    endtask

    task automatic test_bad_nin();
        wr_layer(0, 16'h0a00, 16'h0b00, 16'h0c00, 16'd32, 16'd2);
        wr_layer(1, 16'h0a01, 16'h0b01, 16'h0c01, 16'd20, 16'd2);
        run_layers(2, 1'b0);
        wr(1, 3, 16'd0);
        run_layers(2, 1'b0);
        wr(1, 3, 16'd32);
        wr(1, 4, 16'd0);
        run_layers(2, 1'b0);
    endtask

    task automatic test_zero_layers();
        run_layers(0, 1'b0);
    endtask

    task automatic test_busy_ignore();
        bit seen;
        wr_layer(0, 16'h1234, 16'h5678, 16'h9abc, 16'd16, 16'd1);
        bus.host_start = 1'b1;
        bus.num_layers = 4'd1;
        @(negedge clk);
        bus.host_start = 1'b0;
        bus.host_wr = 1'b1;
        bus.host_addr = 6'd0;
        bus.host_wdata = 16'hffff;
        bus.host_start = 1'b1;
        bus.num_layers = 4'd3;
        @(negedge clk);
        idle_inputs();
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (bus.accel_busrdwr === 1'b1) seen = 1'b1;
        end
        for (int i = 0; i < 20 && bus.accel_busrdwr === 1'b1; i++) begin
            @(negedge clk);
        end
        bus.accel_neuron_done = 1'b1;
        @(negedge clk);
        bus.accel_neuron_done = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            if (bus.done === 1'b1) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL busy_ignore_done: no done within bound");
        end
        @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL busy_ignore_idle: busy=%b exp 0", bus.busy);
        end
        run_layers(1, 1'b0);
    endtask

    task automatic test_rst_mid_send();
        wr_layer(0, 16'h4444, 16'h5555, 16'h6666, 16'd32, 16'd2);
        bus.host_start = 1'b1;
        bus.num_layers = 4'd1;
        @(negedge clk);
        bus.host_start = 1'b0;
        repeat (4) @(negedge clk);
        checks++;
        if (bus.accel_databus !== 16'h6666) begin
            failures++;
            $display("FAIL pre_rst_word2: got %h exp 6666", bus.accel_databus);
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (!outs_zero()) begin
            failures++;
            $display("FAIL rst_mid: busy=%b rdwr=%b data=%h exp 0 0 0",
                     bus.busy, bus.accel_busrdwr, bus.accel_databus);
        end
        rst = 1'b0;
        @(negedge clk);
        run_layers(1, 1'b0);
    endtask

    task automatic test_timeout();
        wr_layer(0, 16'h7000, 16'h7001, 16'h7002, 16'd16, 16'd2);
        bus.host_start = 1'b1;
        bus.num_layers = 4'd1;
        @(negedge clk);
        bus.host_start = 1'b0;
        repeat (7) @(negedge clk);
`ifdef SEQ_TIMEOUT_EN
        repeat (63) @(negedge clk);
        checks++;
        if (bus.busy !== 1'b1) begin
            failures++;
            $display("FAIL wd_early: busy=%b exp 1", bus.busy);
        end
        @(negedge clk);
        checks++;
        if (bus.error !== 1'b1 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            failures++;
            $display("FAIL wd_fire: err=%b busy=%b done=%b exp 1 0 0",
                     bus.error, bus.busy, bus.done);
        end
`else
        repeat (200) @(negedge clk);
        checks++;
        if (bus.busy !== 1'b1 || bus.error !== 1'b0) begin
            failures++;
            $display("FAIL no_wd: busy=%b err=%b exp 1 0",
                     bus.busy, bus.error);
        end
`endif
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_max_layers();
        for (int l = 0; l < MAX_LAYERS; l++) begin
            wr_layer(l, 16'(l * 3), 16'(l * 5), 16'(l * 7),
                     16'(16 * (l + 1)), 16'd1);
        end
        run_layers(MAX_LAYERS, 1'b0);
    endtask

    task automatic test_random();
        int n;
        for (int it = 0; it < 6; it++) begin
            n = $urandom_range(1, 4);
            for (int l = 0; l < n; l++) begin
                wr_layer(l, 16'($urandom), 16'($urandom), 16'($urandom),
                         16'(16 * $urandom_range(1, 8)),
                         16'($urandom_range(1, 5)));
                if ($urandom_range(0, 5) == 0) begin
                    wr(l, 3, 16'(16 * $urandom_range(0, 3) + 8));
                end
            end
            run_layers(n, 1'($urandom_range(0, 1)));
        end
    endtask

    initial begin
        for (int l = 0; l < MAX_LAYERS; l++)
            for (int w = 0; w < NUM_CFG_WORDS; w++)
                tbl[l][w] = '0;
        test_reset();
        test_single();
        test_multi();
        test_bad_nin();
        test_zero_layers();
        test_busy_ignore();
        test_rst_mid_send();
        test_timeout();
        test_max_layers();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
